// File: rtl/onehot_decoder_hold.sv
`default_nettype none
// ---------------------------------------------------------------------------
// onehot_decoder_hold: accepts a 3-bit code over valid/ready and drives a
// one-hot vector plus a 7-segment digit for HOLD_CYCLES cycles. Rev 1.0
// ---------------------------------------------------------------------------
module onehot_decoder_hold #(
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] out_onehot,
  output logic [2:0] out_code,
  output logic       out_valid,
  output logic [7:0] seg_n,
  output logic       done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [7:0]       onehot_nxt, seg_nxt;
  logic [2:0]       code_nxt;
  logic             valid_nxt, done_nxt;

  // Active-low segments, dp off; bit order dp,g,f,e,d,c,b,a.
  function automatic logic [7:0] seg_pattern(input logic [2:0] c);
    logic [7:0] p;
    case (c)
      3'd0:    p = 8'hC0;
      3'd1:    p = 8'hF9;
      3'd2:    p = 8'hA4;
      3'd3:    p = 8'hB0;
      3'd4:    p = 8'h99;
      3'd5:    p = 8'h92;
      3'd6:    p = 8'h82;
      default: p = 8'hF8;
    endcase
    return p;
  endfunction

  assign in_ready = (state == IDLE) && en;

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    onehot_nxt  = out_onehot;
    code_nxt    = out_code;
    valid_nxt   = out_valid;
    seg_nxt     = seg_n;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt   = HOLD;
          counter_nxt = LOAD_VAL;
          onehot_nxt  = 8'b1 << in_code;
          code_nxt    = in_code;
          valid_nxt   = 1'b1;
          seg_nxt     = seg_pattern(in_code);
        end
      end
      HOLD: begin
        if (en && (counter != '0)) begin
          counter_nxt = counter - CNT_W'(1);
        end else begin
          // Abort (en low) and normal expiry both clear; only expiry pulses done.
          state_nxt   = IDLE;
          counter_nxt = '0;
          onehot_nxt  = 8'h00;
          code_nxt    = 3'd0;
          valid_nxt   = 1'b0;
          seg_nxt     = 8'hFF;
          done_nxt    = en;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      out_onehot <= 8'h00;
      out_code   <= 3'd0;
      out_valid  <= 1'b0;
      seg_n      <= 8'hFF;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      out_onehot <= onehot_nxt;
      out_code   <= code_nxt;
      out_valid  <= valid_nxt;
      seg_n      <= seg_nxt;
      done       <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_onehot_decoder_hold.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_onehot_decoder_hold: directed vector bench, HOLD_CYCLES=8 and =1. Rev 1.0
// ---------------------------------------------------------------------------
module tb_onehot_decoder_hold;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic       in_ready, out_valid, done;
  logic [7:0] out_onehot, seg_n;
  logic [2:0] out_code;

  logic       in_valid_1 = 1'b0;
  logic [2:0] in_code_1 = 3'd0;
  logic       in_ready_1, out_valid_1, done_1;
  logic [7:0] out_onehot_1, seg_n_1;
  logic [2:0] out_code_1;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [2:0] code;
    logic [7:0] onehot;
    logic [7:0] seg;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  onehot_decoder_hold #(.HOLD_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .out_onehot(out_onehot), .out_code(out_code),
    .out_valid(out_valid), .seg_n(seg_n), .done(done)
  );

  onehot_decoder_hold #(.HOLD_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid_1), .in_code(in_code_1),
    .in_ready(in_ready_1), .out_onehot(out_onehot_1), .out_code(out_code_1),
    .out_valid(out_valid_1), .seg_n(seg_n_1), .done(done_1)
  );

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string name, input logic [2:0] code,
                            input logic [7:0] onehot, input logic [7:0] seg);
    chk1({name, "_valid"}, out_valid, 1'b1);
    chk8({name, "_onehot"}, out_onehot, onehot);
    chk8({name, "_code"}, {5'd0, out_code}, {5'd0, code});
    chk8({name, "_seg"}, seg_n, seg);
    chk1({name, "_done"}, done, 1'b0);
    chk1({name, "_ready"}, in_ready, 1'b0);
  endtask

  task automatic check_idle(input string name, input logic exp_done);
    chk1({name, "_valid"}, out_valid, 1'b0);
    chk8({name, "_onehot"}, out_onehot, 8'h00);
    chk8({name, "_code"}, {5'd0, out_code}, 8'h00);
    chk8({name, "_seg"}, seg_n, 8'hFF);
    chk1({name, "_done"}, done, exp_done);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 20; i++) begin
      if (in_ready) break;
      step();
    end
    chk1({name, "_timeout"}, in_ready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{3'd0, 8'h01, 8'hC0};
    vecs[1] = '{3'd1, 8'h02, 8'hF9};
    vecs[2] = '{3'd2, 8'h04, 8'hA4};
    vecs[3] = '{3'd3, 8'h08, 8'hB0};
    vecs[4] = '{3'd4, 8'h10, 8'h99};
    vecs[5] = '{3'd5, 8'h20, 8'h92};
    vecs[6] = '{3'd6, 8'h40, 8'h82};
    vecs[7] = '{3'd7, 8'h80, 8'hF8};

    // Reset state
    #12;
    check_idle("reset", 1'b0);
    rst_n = 1'b1;
    step();
    chk1("ready_en0", in_ready, 1'b0);
    en = 1'b1;
    #1;
    chk1("ready_en1", in_ready, 1'b1);

    // Basic decode, single-cycle valid
    step();
    in_code = 3'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check_hold("basic", 3'd3, 8'h08, 8'hB0);
      step();
    end
    check_idle("basic_end", 1'b1);
    step();
    check_idle("basic_after", 1'b0);

    // Full sweep, in_valid held, back-to-back
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_code = vecs[k].code;
      wait_ready("sweep_rdy");
      step();
      for (int c = 0; c < 8; c++) begin
        check_hold("sweep", vecs[k].code, vecs[k].onehot, vecs[k].seg);
        step();
      end
      check_idle("sweep_gap", 1'b1);
      chk1("sweep_gap_ready", in_ready, 1'b1);
      if (done) done_cnt++;
    end
    in_valid = 1'b0;
    chk8("sweep_done_count", 8'(done_cnt), 8'd8);
    step();

    // Ignore during hold
    in_code = 3'd7; in_valid = 1'b1;
    step();
    in_code = 3'd1;
    for (int c = 0; c < 8; c++) begin
      check_hold("ignore", 3'd7, 8'h80, 8'hF8);
      step();
    end
    check_idle("ignore_done", 1'b1);
    chk1("ignore_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check_hold("ignore_next", 3'd1, 8'h02, 8'hF9);
    for (int c = 0; c < 8; c++) step();
    check_idle("ignore_next_done", 1'b1);
    step();

    // Abort at hold cycle 4
    in_code = 3'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check_hold("abort_hold", 3'd2, 8'h04, 8'hA4);
      if (c < 4) step();
    end
    en = 1'b0;
    step();
    check_idle("abort_clear", 1'b0);
    chk1("abort_ready", in_ready, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk1("abort_no_done", done, 1'b0);
      chk1("abort_ready_low", in_ready, 1'b0);
    end
    en = 1'b1;
    #1;
    chk1("abort_ready_back", in_ready, 1'b1);

    // Reset mid-hold
    step();
    in_code = 3'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_hold("rst_hold", 3'd5, 8'h20, 8'h92);
    step(); step();
    check_hold("rst_hold3", 3'd5, 8'h20, 8'h92);
    rst_n = 1'b0;
    #1;
    check_idle("rst_async", 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    chk1("rst_ready", in_ready, 1'b1);

    // Minimum hold on HOLD_CYCLES=1 instance
    step();
    in_code_1 = 3'd6; in_valid_1 = 1'b1;
    step();
    in_valid_1 = 1'b0;
    chk1("min_valid", out_valid_1, 1'b1);
    chk8("min_onehot", out_onehot_1, 8'h40);
    chk8("min_seg", seg_n_1, 8'h82);
    chk1("min_done0", done_1, 1'b0);
    step();
    chk1("min_valid_off", out_valid_1, 1'b0);
    chk8("min_onehot_off", out_onehot_1, 8'h00);
    chk8("min_seg_off", seg_n_1, 8'hFF);
    chk1("min_done1", done_1, 1'b1);
    chk1("min_ready", in_ready_1, 1'b1);
    step();
    chk1("min_done_clr", done_1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/onehot_decoder_hold.md
Name: onehot_decoder_hold

Overview:
- Sequential 3-to-8 decoder. Accepts a 3-bit priority code over a valid/ready handshake and drives an 8-bit one-hot LED vector plus an active-low 7-segment digit of the code.
- Holds the result for a fixed number of cycles, then clears and signals done.
- Sits downstream of the lab's 8-to-3 priority encoder: takes its code/sign outputs and drives the board LEDs and segment display.

Parameters:
- HOLD_CYCLES, 8, number of cycles the decoded outputs stay asserted per accepted code; legal range 1..65535.
- CNT_W, 16, width of the internal hold counter; must satisfy 2^CNT_W > HOLD_CYCLES-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; low blocks acceptance and aborts an active hold.
- in_valid  input  1  a code is presented (driven from the encoder's sign output).
- in_code  input  3  code to decode, 0..7.
- in_ready  output  1  block can accept a code this cycle.
- out_onehot  output  8  one-hot decode, bit in_code set while holding; all zero otherwise.
- out_code  output  3  latched code while holding; 0 otherwise.
- out_valid  output  1  high while outputs are held.
- seg_n  output  8  active-low 7-segment pattern of out_code; bit7=dp, bits6..0=g..a.
- done  output  1  one-cycle pulse when a hold completes normally.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values (immediate on rst_n low, mid-operation included):
  - state=IDLE, counter=0
  - out_onehot=8'h00, out_code=3'd0, out_valid=0, seg_n=8'hFF (blank), done=0
- in_ready is combinational: (state==IDLE) && en. No other inputs feed it.
- Accept: in_valid && in_ready at a rising edge. On the next cycle:
  - out_onehot=1<<in_code, out_code=in_code, out_valid=1, seg_n=pattern(in_code)
  - counter=HOLD_CYCLES-1, state=HOLD
  - Latency from accept edge to outputs: 1 cycle.
- Segment patterns (seg_n, dp off), codes 0..7: C0, F9, A4, B0, 99, 92, 82, F8.
- HOLD state:
  - If en=0: abort. Next cycle clears all outputs to reset values, state=IDLE, done stays 0.
  - Else if counter!=0: counter decrements, outputs unchanged.
  - Else (counter==0): next cycle clears outputs, done=1 for exactly one cycle, state=IDLE.
- Hold duration: out_valid is high for exactly HOLD_CYCLES consecutive cycles per accepted code. HOLD_CYCLES=1 gives a single-cycle output.
- in_valid during HOLD is ignored. There is no queueing; the presenter must keep in_valid high until in_ready is seen.
- Back-to-back: in the cycle done=1 the state is IDLE, so in_ready can be high. A code accepted then loads on the next cycle. Minimum gap between holds is 1 cycle with outputs zero.
- done and a new accept may coincide. done is never asserted while out_valid=1.
- en=0 in IDLE: in_ready=0, outputs stay cleared.
- in_code with X/Z is outside contract; no checking.
- Arithmetic: counter is an unsigned CNT_W-bit down-counter that never wraps, because the zero state exits HOLD.
- out_onehot always satisfies $onehot0; it is exactly one-hot iff out_valid=1.

Test Plan:
- Reset mid-hold: HOLD_CYCLES=8, accept code 5, drop rst_n at hold cycle 3 -> outputs return to 00/0/0/FF immediately without a clock; in_ready=1 after rst_n rises with en=1.
- Basic decode: en=1, in_code=3, in_valid=1 for one cycle -> next cycle out_onehot=8'h08, out_code=3, seg_n=8'hB0, out_valid=1 for 8 cycles; then done=1 for 1 cycle, outputs cleared.
- Full sweep: codes 0..7 back-to-back with in_valid held -> each gives the correct one-hot and segment pattern (C0..F8); exactly 1 zero-output cycle between holds; 8 done pulses.
- Ignore during hold: accept code 7, then present code 1 during hold -> outputs stay 8'h80/F8 for all 8 cycles; code 1 accepted only when in_ready returns.
- Abort: accept code 2, drop en at hold cycle 4 -> next cycle outputs cleared, done never pulses, in_ready=0 until en=1.
- Minimum hold: HOLD_CYCLES=1, accept code 6 -> out_onehot=8'h40 and seg_n=8'h82 for exactly 1 cycle, done the following cycle.
